// File: rtl/mem_pkg.sv
// Shared constants and types for the off-chip line memory and the cache
// controller that talks to it.
package mem_pkg;

    localparam int LINE_W          = 256;
    localparam int OFFSET_W        = 5;
    localparam int DEFAULT_LATENCY = 10;
    localparam int DEFAULT_DEPTH   = 512;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } mem_state_e;

    // Counter preload: the acceptance cycle already counts as one cycle of latency.
    function automatic logic [CNT_W-1:0] cnt_preload(input int unsigned lat);
        return CNT_W'(lat - 32'd1);
    endfunction

endpackage

// File: rtl/line_ram.sv
// DEPTH x LINE_W line storage with a synchronous write port and a registered
// read port that holds its value between reads.
module line_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IDX_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              re_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    // Storage array: contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register: only a read strobe updates it, so the last line read is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency cache-line memory: one request at a time, single-cycle ack
// LATENCY cycles after acceptance.
module line_memory
    import mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int IDX_W   = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o
);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              ram_we_s;
    logic              ram_re_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^{addr_i[31:IDX_W+OFFSET_W], addr_i[OFFSET_W-1:0]};

    // Next-state logic: request latching, latency countdown and ack generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                    cnt_d   = cnt_preload(LATENCY);
                    state_d = (LATENCY == 1) ? ACK : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q > 8'd1) begin
                    cnt_d   = cnt_q - 8'd1;
                    state_d = BUSY;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        ack_d = (state_d == ACK);
    end

    // Read is launched on the edge into ACK so data_o is valid alongside ack_o.
    assign ram_re_s = (state_d == ACK) && !wr_d;
    assign ram_we_s = (state_q == ACK) && wr_q;

    // State, counter and request latches.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
        end
    end

    line_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .idx_i   (idx_d),
        .we_i    (ram_we_s),
        .wdata_i (wdata_q),
        .re_i    (ram_re_s),
        .rdata_o (data_o)
    );

    assign ack_o = ack_q;

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: a LATENCY=10 instance plus a LATENCY=1 instance.
module tb_line_memory;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              en_a, wr_a, ack_a, en_b, wr_b, ack_b;
    logic [31:0]       addr_a, addr_b;
    logic [LINE_W-1:0] din_a, dout_a, din_b, dout_b;

    int checks = 0;
    int errors = 0;

    localparam logic [LINE_W-1:0] PAT_A5   = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_1234 = 256'h1234;

    line_memory #(.LATENCY(10), .DEPTH(512), .IDX_W(9)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en_a), .write_i(wr_a),
        .addr_i(addr_a), .data_i(din_a), .data_o(dout_a), .ack_o(ack_a)
    );

    line_memory #(.LATENCY(1), .DEPTH(512), .IDX_W(9)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en_b), .write_i(wr_b),
        .addr_i(addr_b), .data_i(din_b), .data_o(dout_b), .ack_o(ack_b)
    );

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete request, started and sampled on falling edges.
    task automatic req(input string tag, input bit sel, input bit wr, input logic [31:0] addr,
                       input logic [LINE_W-1:0] din, input int exp_lat);
        int lat;
        lat = -1;
        if (sel) begin
            en_b = 1'b1; wr_b = wr; addr_b = addr; din_b = din;
        end else begin
            en_a = 1'b1; wr_a = wr; addr_a = addr; din_a = din;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((sel ? ack_b : ack_a) === 1'b1) begin
                lat = n;
                break;
            end
        end
        en_a = 1'b0;
        en_b = 1'b0;
        chk({tag, "_lat"}, LINE_W'(lat), LINE_W'(exp_lat));
        @(negedge clk);
        chk({tag, "_ackdrop"}, LINE_W'(sel ? ack_b : ack_a), '0);
    endtask

    initial begin
        int first, cnt, t1, t2;
        rst_n = 1'b0;
        en_a = 1'b0; wr_a = 1'b0; addr_a = 32'h0; din_a = '0;
        en_b = 1'b0; wr_b = 1'b0; addr_b = 32'h0; din_b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack_a", LINE_W'(ack_a), '0);
        chk("rst_data_a", dout_a, '0);
        chk("rst_ack_b", LINE_W'(ack_b), '0);
        chk("rst_data_b", dout_b, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload line 3 and read it back
        req("wr_line3", 1'b0, 1'b1, 32'h60, PAT_A5, 10);
        req("rd_line3", 1'b0, 1'b0, 32'h60, '0, 10);
        chk("rd_line3_data", dout_a, PAT_A5);

        // Write then read through a different offset in the same line
        req("wr_line4", 1'b0, 1'b1, 32'h80, PAT_1234, 10);
        req("rd_9f", 1'b0, 1'b0, 32'h9F, '0, 10);
        chk("rd_9f_data", dout_a, PAT_1234);
        req("rd_line3b", 1'b0, 1'b0, 32'h60, '0, 10);
        chk("rd_line3b_data", dout_a, PAT_A5);

        // Inputs disturbed mid-request: original read of line 4 must complete untouched
        en_a = 1'b1; wr_a = 1'b0; addr_a = 32'h80; din_a = '0;
        first = -1; cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) begin
                addr_a = 32'h60; din_a = {LINE_W{1'b1}}; wr_a = 1'b1; en_a = 1'b0;
            end
            if (ack_a === 1'b1) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        chk("mid_lat", LINE_W'(first), LINE_W'(10));
        chk("mid_ackcount", LINE_W'(cnt), LINE_W'(1));
        chk("mid_data", dout_a, PAT_1234);
        req("mid_line3", 1'b0, 1'b0, 32'h60, '0, 10);
        chk("mid_line3_data", dout_a, PAT_A5);

        // Back-to-back: enable held through the first ack
        en_a = 1'b1; wr_a = 1'b0; addr_a = 32'h60;
        t1 = -1; t2 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin
                if (t1 < 0) begin
                    t1 = n;
                    chk("b2b_data1", dout_a, PAT_A5);
                    addr_a = 32'h80;
                end else begin
                    t2 = n;
                    chk("b2b_data2", dout_a, PAT_1234);
                    en_a = 1'b0;
                    break;
                end
            end
        end
        en_a = 1'b0;
        chk("b2b_t1", LINE_W'(t1), LINE_W'(10));
        chk("b2b_gap", LINE_W'(t2 - t1), LINE_W'(11));
        @(negedge clk);

        // Wrap-around: 0x4000 aliases line 0
        req("wr_line0", 1'b0, 1'b1, 32'h0, 256'h1111, 10);
        req("rd_line0", 1'b0, 1'b0, 32'h0, '0, 10);
        chk("rd_line0_data", dout_a, 256'h1111);
        req("wr_4000", 1'b0, 1'b1, 32'h4000, 256'hBEEF, 10);
        req("rd_line0w", 1'b0, 1'b0, 32'h0, '0, 10);
        chk("wrap_data", dout_a, 256'hBEEF);

        // Reset in the middle of a write to line 3
        en_a = 1'b1; wr_a = 1'b1; addr_a = 32'h60; din_a = 256'hDEAD;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            en_a = 1'b0;
        end
        rst_n = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (ack_a === 1'b1) cnt++;
        end
        chk("rstmid_noack", LINE_W'(cnt), '0);
        chk("rstmid_data", dout_a, '0);
        rst_n = 1'b1;
        @(negedge clk);
        req("rstmid_rd", 1'b0, 1'b0, 32'h60, '0, 10);
        chk("rstmid_line3", dout_a, PAT_A5);

        // LATENCY=1 instance
        req("l1_wr", 1'b1, 1'b1, 32'h20, 256'h77, 1);
        req("l1_rd", 1'b1, 1'b0, 32'h20, '0, 1);
        chk("l1_data", dout_b, 256'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_memory.md
# line_memory

Off-chip data memory model that sits directly downstream of the CPU's data-cache memory port. It stores whole 256-bit cache lines, accepts one read or write request at a time on the `mem_*` interface, and completes each request after a fixed, programmable latency. It completes the request with a single-cycle acknowledge. It is the block the CPU's `mem_data_o/mem_addr_o/mem_enable_o/mem_write_o` outputs drive and whose `data_o/ack_o` feed `mem_data_i/mem_ack_i`.

## Interface
Parameters:
- `LATENCY`, 10, cycles from request acceptance to `ack_o`; legal range 1..255.
- `DEPTH`, 512, number of 256-bit lines stored; power of two.
- `IDX_W`, 9, log2(`DEPTH`).

Ports:
- `clk_i`  in  1  clock. One clock; everything is sampled on its rising edge.
- `rst_i`  in  1  reset. Asynchronous and active-low.
- `enable_i`  in  1  request valid. Held high by the requester until `ack_o`.
- `write_i`  in  1  1 = write line, 0 = read line. Sampled only when a request is accepted.
- `addr_i`  in  32  byte address. Line index = `addr_i[IDX_W+4:5]`. Bits [4:0] and bits above the index are ignored.
- `data_i`  in  256  write line data. Sampled at acceptance.
- `data_o`  out  256  read line data. Valid in the `ack_o` cycle of a read, and held until the next read completes.
- `ack_o`  out  1  request complete. One-cycle pulse.

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - If `enable_i`=1, accept the request: latch index, `write_i` and `data_i`.
  - Load the counter with `LATENCY`-1, then go to BUSY, or go directly to ACK if `LATENCY`=1.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to ACK.
  - All inputs are ignored in this state. Dropping `enable_i` does not abort the request; it still completes.
- ACK:
  - `ack_o`=1 for exactly this cycle.
  - Write: the latched data is committed to the latched line at the end of this cycle.
  - Read: `data_o` shows the stored line, with write-before-read order across requests.
  - Next state is IDLE unconditionally.
- After ACK there is at least one IDLE cycle. If `enable_i` is still high there, it is taken as a new request. The requester must drop `enable_i` in the cycle after `ack_o` if it has no further request.
- Index arithmetic wraps modulo `DEPTH`: addresses beyond the array alias lower lines.
- Reset values: `ack_o`=0, `data_o`=0, state=IDLE, counter=0.
- Storage contents are not cleared by reset; the bench preloads them.
- Reset asserted mid-request: the FSM goes to IDLE immediately, no `ack_o` is issued, and a pending write is discarded (the storage is not modified).

## Timing
- Request accepted at edge T, i.e. `enable_i`=1 while in IDLE.
- `ack_o` is high in cycle T+`LATENCY` and low in every other cycle.
- Read data is registered and valid in the same cycle as `ack_o`.
- A written line becomes visible to any read accepted after the write's ACK cycle.
- Maximum throughput is one request per `LATENCY`+1 cycles.

## Structure
- Shared package `mem_pkg`:
  - `LINE_W`=256 and `OFFSET_W`=5.
  - State enum {IDLE, BUSY, ACK}.
  - Default `LATENCY`.
  - The CPU's cache controller imports the same line-width constants.
- One sub-module, `line_ram`:
  - Array of `DEPTH` x `LINE_W`.
  - Synchronous write enable, registered read.
  - Driven by the FSM only in the ACK cycle.
- The FSM, the latency counter and the request latches live in `line_memory`.

## Test plan
- Read latency: preload line 3 = 256'hA5…A5; request a read at `addr_i`=32'h60 accepted at T → `ack_o` high only at T+10, `data_o`=A5…A5.
- Write then read: write 256'h1234 to `addr_i`=32'h80, then read 32'h9F (same line) → read returns 256'h1234; line 3 is unchanged.
- Inputs mid-request: change `addr_i`, `data_i` and `write_i` and drop `enable_i` during BUSY → the original request completes unchanged at T+10, with exactly one `ack_o`.
- Back-to-back requests: hold `enable_i` high through `ack_o` → the second request is accepted in the following IDLE cycle, and its `ack_o` arrives `LATENCY`+1 cycles after the first.
- Wrap-around: with `DEPTH`=512, write to `addr_i`=32'h4000 → line 0 is modified.
- Reset mid-write: assert `rst_i` low at T+4 of a write → `ack_o` stays 0, the target line retains its old value, and a new request after reset completes normally.
- Parameter edge: `LATENCY`=1 → `ack_o` high in the cycle immediately after acceptance.
